load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the 32-word data memory in the single-cycle MIPS datapath.
- Converts byte-addressed lw/lh/lhu/lb/lbu/sw/sh/sb requests from the ALU/control into word-indexed memory accesses.
- Sub-word stores are done as a 2-cycle read-modify-write, with a stall to the PC logic.
- Loads are extracted with sign or zero extension; misaligned accesses are flagged and counted.

Parameters:
- ADDR_BITS, 5, word-index width driven to memory (32 words); mem_A = {zeros, addr[ADDR_BITS+1:2]}.
- CNT_W, 8, width of the saturating misalignment counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- sign_ext  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- addr  in  32  byte address from ALU.
- wdata  in  32  store data; sub-word stores use the low byte or half.
- mem_RD  in  32  data memory read data, combinational for mem_A.
- mem_A  out  32  word index to data memory.
- mem_WD  out  32  write data to data memory.
- mem_WE  out  1  write enable to data memory.
- rdata  out  32  extended load result to writeback mux.
- stall  out  1  hold PC/instruction this cycle.
- misaligned  out  1  registered one-cycle pulse on a misaligned access.
- fault_count  out  CNT_W  saturating count of misaligned accesses.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous and active-high.
  - Reset values: state=IDLE, merge register 0, index register 0, misaligned=0, fault_count=0.
  - While rst=1, mem_WE=0 and stall=0 regardless of inputs.
- Byte ordering: little-endian.
  - Byte lane = addr[1:0]; lane 0 = bits[7:0].
  - Halfword lane = addr[1]; lane 1 = bits[31:16].
- Alignment:
  - Halfword is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]!=0.
  - Byte accesses are never misaligned.
- Misaligned access:
  - No write and no stall.
  - rdata=0.
  - misaligned pulses high for the next cycle.
  - fault_count increments, saturating at all-ones.
- Address upper bits above ADDR_BITS+1 are ignored, so addresses wrap modulo 128 bytes.
- Loads (IDLE, mem_read=1, mem_write=0, aligned):
  - Combinational, zero latency.
  - mem_A from addr; rdata is the selected lane of mem_RD, extended per sign_ext.
  - Word loads ignore sign_ext.
- rdata is 0 whenever mem_read=0.
- If mem_read and mem_write are both 1, the request is treated as a store and rdata=0.
- Word store (IDLE, aligned): single cycle; mem_WE=1, mem_WD=wdata, stall=0.
- Sub-word store is a 2-state FSM, IDLE to MERGE_WR:
  - IDLE, aligned byte/half store:
    - stall=1 combinationally and mem_WE=0.
    - mem_A is driven from addr.
    - The merge register captures mem_RD with the target lane replaced by wdata[7:0] or wdata[15:0].
    - The index register captures mem_A.
    - Next state is MERGE_WR.
  - MERGE_WR:
    - mem_A = index register, mem_WD = merge register, mem_WE=1, stall=0.
    - All request inputs are ignored; the same instruction is still presented and must not retrigger.
    - Next state is always IDLE.
  - Stores never stall in MERGE_WR; sub-word store latency is exactly 2 cycles.
- mem_WD is 0 and mem_WE is 0 whenever no write is being issued.
- A reset asserted in MERGE_WR aborts the write (mem_WE=0 that cycle) and returns to IDLE.
- A misaligned fault raised in the same cycle as a saturated counter leaves the counter at max while misaligned still pulses.

Test Plan:
- Reset, then lb from addr 0x3 with mem_RD=0x80FF_1234 and sign_ext=1 -> rdata=0xFFFF_FF80, mem_A=0, stall=0; same access with sign_ext=0 -> rdata=0x0000_0080.
- sh wdata=0x0000_BEEF to addr 0x0A with mem_RD=0x1122_3344:
  - cycle 1: stall=1, WE=0, mem_A=2.
  - cycle 2: WE=1, mem_WD=0xBEEF_3344, mem_A=2, stall=0.
  - cycle 3: back in IDLE with no re-write.
- sw 0xDEAD_BEEF to addr 0x7C -> single cycle, mem_A=31, WE=1, WD=0xDEAD_BEEF; the same store to addr 0xFC also gives mem_A=31 (wrap).
- lw at addr 0x06 -> rdata=0, WE=0, misaligned=1 the next cycle, fault_count 0->1; 300 such accesses -> fault_count=255.
- sb to addr 0x01 with rst asserted during MERGE_WR -> mem_WE stays 0, state IDLE, next sb completes normally in 2 cycles.
- mem_read=mem_write=1, word, addr 0x10, wdata=0x5 -> WE=1, WD=0x5, rdata=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response bundle between the ALU/control side, the load/store unit and the data memory.
interface load_store_unit_if #(parameter int CNT_W = 8);
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       size;
    logic             sign_ext;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      mem_RD;
    logic [31:0]      mem_A;
    logic [31:0]      mem_WD;
    logic             mem_WE;
    logic [31:0]      rdata;
    logic             stall;
    logic             misaligned;
    logic [CNT_W-1:0] fault_count;

    // Handshake: there is no valid/ready pair; a request is live for every cycle
    // mem_read or mem_write is high, and stall=1 means the same request must be held.
    modport slave (
        input  mem_read, mem_write, size, sign_ext, addr, wdata, mem_RD,
        output mem_A, mem_WD, mem_WE, rdata, stall, misaligned, fault_count
    );
    modport master (
        output mem_read, mem_write, size, sign_ext, addr, wdata, mem_RD,
        input  mem_A, mem_WD, mem_WE, rdata, stall, misaligned, fault_count
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a 32-word data memory: lane extraction,
// sub-word read-modify-write stores, and misalignment detection/counting.
module load_store_unit #(
    parameter int ADDR_BITS = 5,
    parameter int CNT_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    load_store_unit_if.slave bus,
    output logic            dbg_state
);
    localparam int PAD = 32 - ADDR_BITS;

    typedef enum logic {IDLE = 1'b0, MERGE_WR = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [31:0]          merge_q, merge_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic                 mis_q, mis_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 is_word, is_half, misalign;
    logic                 req_fault, do_word_st, do_sub_st, do_load;
    logic [ADDR_BITS-1:0] addr_idx;
    logic [31:0]          merged, load_val;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic                 unused_addr_hi;

    assign addr_idx       = bus.addr[ADDR_BITS+1:2];
    assign unused_addr_hi = ^bus.addr[31:ADDR_BITS+2];
    assign is_word        = bus.size[1];
    assign is_half        = (bus.size == 2'b01);
    assign misalign       = is_word ? (bus.addr[1:0] != 2'b00) : (is_half & bus.addr[0]);
    assign req_fault      = (bus.mem_read | bus.mem_write) & misalign;
    // A simultaneous read+write is a store; the read side is dropped.
    assign do_word_st     = bus.mem_write & is_word & ~misalign;
    assign do_sub_st      = bus.mem_write & ~is_word & ~misalign;
    assign do_load        = bus.mem_read & ~bus.mem_write & ~misalign;

    always_comb begin
        merged = bus.mem_RD;
        if (is_half) begin
            if (bus.addr[1]) merged[31:16] = bus.wdata[15:0];
            else             merged[15:0]  = bus.wdata[15:0];
        end else begin
            case (bus.addr[1:0])
                2'd0:    merged[7:0]   = bus.wdata[7:0];
                2'd1:    merged[15:8]  = bus.wdata[7:0];
                2'd2:    merged[23:16] = bus.wdata[7:0];
                default: merged[31:24] = bus.wdata[7:0];
            endcase
        end
    end

    always_comb begin
        case (bus.addr[1:0])
            2'd0:    ld_byte = bus.mem_RD[7:0];
            2'd1:    ld_byte = bus.mem_RD[15:8];
            2'd2:    ld_byte = bus.mem_RD[23:16];
            default: ld_byte = bus.mem_RD[31:24];
        endcase
        ld_half = bus.addr[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];
        if (is_word)      load_val = bus.mem_RD;
        else if (is_half) load_val = {{16{bus.sign_ext & ld_half[15]}}, ld_half};
        else              load_val = {{24{bus.sign_ext & ld_byte[7]}}, ld_byte};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            merge_q <= '0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        idx_d   = idx_q;
        mis_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_fault) begin
                    mis_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                end else if (do_sub_st) begin
                    state_d = MERGE_WR;
                    merge_d = merged;
                    idx_d   = addr_idx;
                end
            end
            // The stalled instruction is still on the inputs here; it must not restart.
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_A  = {{PAD{1'b0}}, addr_idx};
        bus.mem_WD = '0;
        bus.mem_WE = 1'b0;
        bus.rdata  = '0;
        bus.stall  = 1'b0;
        if (state_q == MERGE_WR) begin
            bus.mem_A = {{PAD{1'b0}}, idx_q};
            if (!rst) begin
                bus.mem_WE = 1'b1;
                bus.mem_WD = merge_q;
            end
        end else begin
            if (!rst && do_word_st) begin
                bus.mem_WE = 1'b1;
                bus.mem_WD = bus.wdata;
            end
            if (!rst && do_sub_st) bus.stall = 1'b1;
            if (do_load) bus.rdata = load_val;
        end
    end

    assign bus.misaligned  = mis_q;
    assign bus.fault_count = cnt_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a word-array memory reference.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  load_store_unit_if #(.CNT_W(8)) bus ();
  load_store_unit #(.ADDR_BITS(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // data memory plus a preload port used only during reset
  logic [31:0] mem [32];
  logic        pre_en;
  logic [4:0]  pre_idx;
  logic [31:0] pre_val;
  assign bus.mem_RD = mem[bus.mem_A[4:0]];
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.mem_WE) mem[bus.mem_A[4:0]] <= bus.mem_WD;
  end

  // reference model state
  logic [31:0] ref_mem [32];
  bit          m_pend;
  logic [4:0]  m_pidx;
  logic [31:0] m_pdata;
  int          m_cnt;
  logic        m_mis;

  logic [31:0] o_rdata, o_wd, o_a;
  logic        o_we, o_stall;
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic se, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] e_rdata, e_wd, w;
    logic [15:0] h;
    logic [7:0]  b;
    logic        e_we, e_stall, chk_a;
    int idx, lane;
    bit word, half, mis, fault;
    @(negedge clk);
    rst = r; bus.mem_read = rd; bus.mem_write = wr; bus.size = sz;
    bus.sign_ext = se; bus.addr = a; bus.wdata = wd;
    #1;
    idx = int'((a / 4) % 32);
    lane = int'(a % 4);
    word = (sz >= 2);
    half = (sz == 1);
    mis = word ? (lane != 0) : (half ? (lane % 2 == 1) : 1'b0);
    fault = 1'b0;
    e_rdata = 0; e_wd = 0; e_we = 0; e_stall = 0; chk_a = 0;
    if (r) begin
    end else if (m_pend) begin
      e_we = 1; e_wd = m_pdata; chk_a = 1;
    end else if ((rd || wr) && mis) begin
      fault = 1'b1;
    end else if (wr && word) begin
      e_we = 1; e_wd = wd; chk_a = 1;
    end else if (wr) begin
      e_stall = 1; chk_a = 1;
    end else if (rd) begin
      chk_a = 1;
      w = ref_mem[idx];
      if (word) e_rdata = w;
      else if (half) begin
        h = w[16*(lane/2) +: 16];
        e_rdata = se ? 32'($signed(h)) : 32'(h);
      end else begin
        b = w[8*lane +: 8];
        e_rdata = se ? 32'($signed(b)) : 32'(b);
      end
    end
    o_rdata = bus.rdata; o_wd = bus.mem_WD; o_we = bus.mem_WE;
    o_stall = bus.stall; o_a = bus.mem_A;
    chk("mem_WE", 32'(o_we), 32'(e_we));
    chk("stall", 32'(o_stall), 32'(e_stall));
    chk("mem_WD", o_wd, e_wd);
    if (!r) chk("rdata", o_rdata, e_rdata);
    if (chk_a) chk("mem_A", o_a, m_pend ? 32'(m_pidx) : 32'(idx));
    @(posedge clk);
    #1;
    if (r) begin
      m_pend = 0; m_cnt = 0; m_mis = 0;
    end else if (m_pend) begin
      ref_mem[m_pidx] = m_pdata; m_pend = 0; m_mis = 0;
    end else if (fault) begin
      m_mis = 1;
      if (m_cnt < 255) m_cnt++;
    end else begin
      m_mis = 0;
      if (wr && word) ref_mem[idx] = wd;
      else if (wr) begin
        w = ref_mem[idx];
        if (half) w[16*(lane/2) +: 16] = wd[15:0];
        else      w[8*lane +: 8] = wd[7:0];
        m_pend = 1; m_pidx = 5'(idx); m_pdata = w;
      end
    end
    chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
    chk("fault_count", 32'(bus.fault_count), 32'(m_cnt));
    chk("dbg_state", 32'(dbg_state), 32'(m_pend));
  endtask

  initial begin
    logic [31:0] v;
    int op;
    rst = 1; pre_en = 0; pre_idx = 0; pre_val = 0;
    bus.mem_read = 0; bus.mem_write = 0; bus.size = 0; bus.sign_ext = 0;
    bus.addr = 0; bus.wdata = 0;
    m_pend = 0; m_pidx = 0; m_pdata = 0; m_cnt = 0; m_mis = 0;
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'h80FF_1234 : (i == 2) ? 32'h1122_3344 : $urandom;
      @(negedge clk);
      pre_en = 1; pre_idx = 5'(i); pre_val = v; ref_mem[i] = v;
    end
    @(negedge clk);
    pre_en = 0;

    // reset state
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);

    // byte loads with sign and zero extension
    cycle(0, 1, 0, 2'b00, 1, 32'h3, 0);
    chk("lb_sx_rdata", o_rdata, 32'hFFFF_FF80);
    chk("lb_sx_memA", o_a, 32'd0);
    cycle(0, 1, 0, 2'b00, 0, 32'h3, 0);
    chk("lb_zx_rdata", o_rdata, 32'h0000_0080);

    // halfword store read-modify-write
    cycle(0, 0, 1, 2'b01, 0, 32'h0A, 32'h0000_BEEF);
    chk("sh_c1_stall", 32'(o_stall), 32'd1);
    chk("sh_c1_memA", o_a, 32'd2);
    cycle(0, 0, 1, 2'b01, 0, 32'h0A, 32'h0000_BEEF);
    chk("sh_c2_we", 32'(o_we), 32'd1);
    chk("sh_c2_wd", o_wd, 32'hBEEF_3344);
    chk("sh_c2_memA", o_a, 32'd2);
    cycle(0, 0, 0, 2'b01, 0, 32'h0A, 32'h0000_BEEF);
    chk("sh_c3_we", 32'(o_we), 32'd0);
    chk("sh_mem", mem[2], 32'hBEEF_3344);

    // word store and address wrap
    cycle(0, 0, 1, 2'b10, 0, 32'h7C, 32'hDEAD_BEEF);
    chk("sw_memA", o_a, 32'd31);
    chk("sw_wd", o_wd, 32'hDEAD_BEEF);
    cycle(0, 0, 1, 2'b10, 0, 32'hFC, 32'hDEAD_BEEF);
    chk("sw_wrap_memA", o_a, 32'd31);

    // misaligned word loads and counter saturation
    cycle(0, 1, 0, 2'b10, 0, 32'h06, 0);
    chk("lw_mis_rdata", o_rdata, 32'd0);
    chk("lw_mis_pulse", 32'(bus.misaligned), 32'd1);
    chk("lw_mis_cnt1", 32'(bus.fault_count), 32'd1);
    for (int i = 0; i < 299; i++) cycle(0, 1, 0, 2'b10, 0, 32'h06, 0);
    chk("cnt_sat", 32'(bus.fault_count), 32'd255);

    // reset during merge write aborts it
    cycle(0, 0, 1, 2'b00, 0, 32'h01, 32'h0000_00A5);
    cycle(1, 0, 1, 2'b00, 0, 32'h01, 32'h0000_00A5);
    chk("sb_abort_we", 32'(o_we), 32'd0);
    chk("sb_abort_idle", 32'(dbg_state), 32'd0);
    cycle(0, 0, 1, 2'b00, 0, 32'h01, 32'h0000_00A5);
    chk("sb_retry_stall", 32'(o_stall), 32'd1);
    cycle(0, 0, 1, 2'b00, 0, 32'h01, 32'h0000_00A5);
    chk("sb_retry_we", 32'(o_we), 32'd1);

    // read+write together acts as a store
    cycle(0, 1, 1, 2'b10, 0, 32'h10, 32'h5);
    chk("rw_we", 32'(o_we), 32'd1);
    chk("rw_wd", o_wd, 32'h5);
    chk("rw_rdata", o_rdata, 32'd0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      op = $urandom_range(0, 3);
      cycle(($urandom_range(0, 49) == 0), op[0], op[1], 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) chk($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
